// File: rtl/p4sched_pkg.sv
// Shared definitions for the round-robin P4 adder scheduler.
//   state_e            : scheduler FSM states
//   NBIT_DEF/NREQ_DEF  : default operand width and requester count
//   clog2()            : index width helper for parameter defaults
package p4sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NBIT_DEF = 32;
  localparam int NREQ_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/P4ADDER_NBIT32.sv
// 32-bit P4 sparse-tree adder core: a prefix tree produces one carry every
// four bits, and each 4-bit block picks between precomputed sums for carry-in
// 0 and 1.
// Ports: A, B (operands), Ci (carry in), S (sum), Co (carry out).
module P4ADDER_NBIT32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Ci,
  output logic [31:0] S,
  output logic        Co
);

  logic [31:0] g, p;
  logic [7:0]  blk_g, blk_p, gg, pp, gn, pn;
  logic [8:0]  c4;
  logic [3:0]  sum0, sum1;

  always_comb begin
    g     = A & B;
    p     = A ^ B;
    blk_g = '0;
    blk_p = '0;
    for (int k = 0; k < 8; k++) begin
      blk_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
                 (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                 (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      blk_p[k] = &p[4*k +: 4];
    end
    // Ci is folded into block 0 so every tree output is a true carry.
    gg    = blk_g;
    pp    = blk_p;
    gg[0] = blk_g[0] | (blk_p[0] & Ci);
    gn    = gg;
    pn    = pp;
    for (int lvl = 0; lvl < 3; lvl++) begin
      gn = gg;
      pn = pp;
      for (int k = 0; k < 8; k++) begin
        if (k >= (1 << lvl)) begin
          gn[k] = gg[k] | (pp[k] & gg[k-(1<<lvl)]);
          pn[k] = pp[k] & pp[k-(1<<lvl)];
        end
      end
      gg = gn;
      pp = pn;
    end
    c4 = {gg, Ci};
  end

  always_comb begin
    S    = '0;
    sum0 = '0;
    sum1 = '0;
    for (int k = 0; k < 8; k++) begin
      sum0 = A[4*k +: 4] + B[4*k +: 4];
      sum1 = sum0 + 4'd1;
      S[4*k +: 4] = c4[k] ? sum1 : sum0;
    end
  end

  assign Co = c4[8];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Scans requests starting one past the
// pointer and wrapping; the first set bit wins. The pointer register lives in
// the caller.
// Ports: req_i (request vector), ptr_i (last winner), en_i (arbitration
// enable), gnt_o (one-hot grant), idx_o (encoded winner).
module rr_arbiter
  import p4sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  int             cand;
  logic [IDW-1:0] cidx;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      cidx = IDW'(cand);
      if (en_i && !found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/p4adder_rr_sched.sv
// Round-robin scheduler sharing one P4ADDER_NBIT32 among NREQ requesters.
// One operation per grant: IDLE accepts, EXEC lets the adder settle on the
// operand registers, DONE presents the result until RES_READY.
// Ports: CLK/RST (async active-high), REQ_VALID/REQ_READY/REQ_A/REQ_B/REQ_SUB
// request side, RES_VALID/RES_READY/RES_S/RES_CO/RES_ID result side, BUSY.
// Build option: define P4SCHED_OVF_EN to add RES_OVF (signed overflow flag).
//
// state | meaning
// IDLE  | arbitrate; grant drives REQ_READY, accept captures operands
// EXEC  | adder evaluates operand registers; result registered on exit
// DONE  | RES_VALID high, result held until RES_READY
module p4adder_rr_sched
  import p4sched_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*NBIT-1:0] REQ_A,
  input  logic [NREQ*NBIT-1:0] REQ_B,
  input  logic [NREQ-1:0]      REQ_SUB,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [NBIT-1:0]      RES_S,
  output logic                 RES_CO,
  output logic [IDW-1:0]       RES_ID,
`ifdef P4SCHED_OVF_EN
  output logic                 RES_OVF,
`endif
  output logic                 BUSY
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, id_q, res_id_q, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [NBIT-1:0]   opa_q, opb_q, res_s_q, sel_a, sel_b, add_s;
  logic              opci_q, res_co_q, sel_sub, add_co, accept;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  P4ADDER_NBIT32 u_adder (
    .A  (opa_q),
    .B  (opb_q),
    .Ci (opci_q),
    .S  (add_s),
    .Co (add_co)
  );

  assign accept = |gnt;

  always_comb begin
    sel_a   = REQ_A[int'(gnt_idx)*NBIT +: NBIT];
    sel_b   = REQ_B[int'(gnt_idx)*NBIT +: NBIT];
    sel_sub = REQ_SUB[gnt_idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Subtract is A + ~B + 1, so inversion happens before the operand register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q  <= IDW'(NREQ-1);
      opa_q  <= '0;
      opb_q  <= '0;
      opci_q <= 1'b0;
      id_q   <= '0;
    end else if (accept) begin
      ptr_q  <= gnt_idx;
      opa_q  <= sel_a;
      opb_q  <= sel_sub ? ~sel_b : sel_b;
      opci_q <= sel_sub;
      id_q   <= gnt_idx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_s_q  <= '0;
      res_co_q <= 1'b0;
      res_id_q <= '0;
    end else if (state_q == EXEC) begin
      res_s_q  <= add_s;
      res_co_q <= add_co;
      res_id_q <= id_q;
    end
  end

`ifdef P4SCHED_OVF_EN
  logic res_ovf_q;

  // Same-sign operands producing an opposite-sign sum; opb_q is already
  // inverted for subtract, so one rule covers both operations.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) res_ovf_q <= 1'b0;
    else if (state_q == EXEC)
      res_ovf_q <= (opa_q[NBIT-1] == opb_q[NBIT-1]) && (add_s[NBIT-1] != opa_q[NBIT-1]);
  end

  assign RES_OVF = res_ovf_q;
`endif

  assign REQ_READY = gnt;
  assign RES_VALID = (state_q == DONE);
  assign RES_S     = res_s_q;
  assign RES_CO    = res_co_q;
  assign RES_ID    = res_id_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_p4adder_rr_sched.sv
// Self-checking bench for p4adder_rr_sched. Accepted requests are modelled
// and queued at acceptance; results are popped and compared when RES_VALID
// is seen. Build with P4SCHED_OVF_EN to also check RES_OVF.
module tb_p4adder_rr_sched;

  localparam int NBIT = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      REQ_VALID, REQ_READY, REQ_SUB;
  logic [NREQ*NBIT-1:0] REQ_A, REQ_B;
  logic                 RES_VALID, RES_READY, RES_CO, BUSY;
  logic [NBIT-1:0]      RES_S;
  logic [IDW-1:0]       RES_ID;
`ifdef P4SCHED_OVF_EN
  logic                 RES_OVF;
`endif

  typedef struct {
    logic [NBIT-1:0] s;
    logic            co;
    logic [IDW-1:0]  id;
    logic            ovf;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  localparam int              N_OPS = 6;
  localparam int              OP_ID  [N_OPS] = '{0, 2, 3, 1, 0, 1};
  localparam logic [NBIT-1:0] OP_A   [N_OPS] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0005,
                                                 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
  localparam logic [NBIT-1:0] OP_B   [N_OPS] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0003,
                                                 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
  localparam logic            OP_SUB [N_OPS] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  p4adder_rr_sched dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_SUB   (REQ_SUB),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_S     (RES_S),
    .RES_CO    (RES_CO),
    .RES_ID    (RES_ID),
`ifdef P4SCHED_OVF_EN
    .RES_OVF   (RES_OVF),
`endif
    .BUSY      (BUSY)
  );

  // Plain arithmetic reference: unsigned compare gives the no-borrow flag.
  function automatic exp_t model(input int id, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                 input logic sub, input int c);
    exp_t            e;
    logic [NBIT:0]   full;
    if (sub) begin
      e.s   = a - b;
      e.co  = (a >= b);
      e.ovf = (a[NBIT-1] != b[NBIT-1]) && (e.s[NBIT-1] != a[NBIT-1]);
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      e.s   = full[NBIT-1:0];
      e.co  = full[NBIT];
      e.ovf = (a[NBIT-1] == b[NBIT-1]) && (e.s[NBIT-1] != a[NBIT-1]);
    end
    e.id  = IDW'(id);
    e.acc = c;
    return e;
  endfunction

  // Acceptance monitor: VALID&READY seen here is accepted at the next edge.
  always @(negedge CLK) begin
    for (int i = 0; i < NREQ; i++)
      if (!RST && REQ_VALID[i] && REQ_READY[i])
        sb.push_back(model(i, REQ_A[i*NBIT +: NBIT], REQ_B[i*NBIT +: NBIT], REQ_SUB[i], cyc));
  end

  task automatic issue(input int id, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                       input logic sub, output bit ok);
    @(posedge CLK); #1;
    REQ_A[id*NBIT +: NBIT] = a;
    REQ_B[id*NBIT +: NBIT] = b;
    REQ_SUB[id]   = sub;
    REQ_VALID[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (REQ_READY[id] === 1'b1) ok = 1'b1;
    end
    @(posedge CLK); #1;
    REQ_VALID[id] = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (RES_VALID === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++; if (REQ_READY !== '0) $display("FAIL rst_req_ready: got %b exp 0", REQ_READY); else n_pass++;
    n_checks++; if (RES_VALID !== 1'b0) $display("FAIL rst_res_valid: got %b exp 0", RES_VALID); else n_pass++;
    n_checks++; if (RES_S !== '0) $display("FAIL rst_res_s: got %h exp 0", RES_S); else n_pass++;
    n_checks++; if (RES_CO !== 1'b0) $display("FAIL rst_res_co: got %b exp 0", RES_CO); else n_pass++;
    n_checks++; if (RES_ID !== '0) $display("FAIL rst_res_id: got %0d exp 0", RES_ID); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b exp 0", BUSY); else n_pass++;
`ifdef P4SCHED_OVF_EN
    n_checks++; if (RES_OVF !== 1'b0) $display("FAIL rst_res_ovf: got %b exp 0", RES_OVF); else n_pass++;
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || REQ_READY !== '0) $display("FAIL idle_no_req: busy %b ready %b exp 0/0", BUSY, REQ_READY); else n_pass++;
  endtask

  task automatic test_arith();
    bit   ok;
    exp_t e;
    RES_READY = 1'b1;
    for (int n = 0; n < N_OPS; n++) begin
      issue(OP_ID[n], OP_A[n], OP_B[n], OP_SUB[n], ok);
      n_checks++; if (!ok) $display("FAIL arith%0d_grant: got no grant exp grant", n); else n_pass++;
      wait_valid(ok);
      n_checks++; if (!ok || sb.size() == 0) $display("FAIL arith%0d_result: got no result exp result", n);
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (RES_S !== e.s) $display("FAIL arith%0d_s: got %h exp %h", n, RES_S, e.s); else n_pass++;
        n_checks++; if (RES_CO !== e.co) $display("FAIL arith%0d_co: got %b exp %b", n, RES_CO, e.co); else n_pass++;
        n_checks++; if (RES_ID !== IDW'(OP_ID[n])) $display("FAIL arith%0d_id: got %0d exp %0d", n, RES_ID, OP_ID[n]); else n_pass++;
        n_checks++; if (cyc - e.acc != 2) $display("FAIL arith%0d_latency: got %0d exp 2", n, cyc - e.acc); else n_pass++;
        n_checks++; if (BUSY !== 1'b1) $display("FAIL arith%0d_busy: got %b exp 1", n, BUSY); else n_pass++;
`ifdef P4SCHED_OVF_EN
        n_checks++; if (RES_OVF !== e.ovf) $display("FAIL arith%0d_ovf: got %b exp %b", n, RES_OVF, e.ovf); else n_pass++;
`endif
      end
    end
  endtask

  task automatic test_round_robin();
    bit   ok;
    exp_t e;
    int   last;
    int   order[6];
    order = '{0, 1, 2, 3, 0, 1};
    last  = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sb.delete();
    RES_READY = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      REQ_A[i*NBIT +: NBIT] = $urandom;
      REQ_B[i*NBIT +: NBIT] = $urandom;
      REQ_SUB[i] = i[0];
    end
    REQ_VALID = '1;
    for (int k = 0; k < 6; k++) begin
      wait_valid(ok);
      n_checks++; if (!ok || sb.size() == 0) $display("FAIL rr%0d_result: got no result exp result", k);
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (RES_ID !== IDW'(order[k])) $display("FAIL rr%0d_id: got %0d exp %0d", k, RES_ID, order[k]); else n_pass++;
        n_checks++; if (RES_S !== e.s || RES_CO !== e.co) $display("FAIL rr%0d_s: got %h/%b exp %h/%b", k, RES_S, RES_CO, e.s, e.co); else n_pass++;
        if (k > 0) begin
          n_checks++; if (cyc - last != 3) $display("FAIL rr%0d_interval: got %0d exp 3", k, cyc - last); else n_pass++;
        end
        last = cyc;
      end
    end
    @(posedge CLK); #1;
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0 || sb.size() != 0) $display("FAIL rr_drain: got busy %b queued %0d exp 0/0", BUSY, sb.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    issue(2, 32'h1234_5678, 32'h0000_1111, 1'b1, ok);
    n_checks++; if (!ok) $display("FAIL bp_grant: got no grant exp grant"); else n_pass++;
    REQ_A[0 +: NBIT] = 32'h0000_00A0;
    REQ_B[0 +: NBIT] = 32'h0000_000B;
    REQ_SUB[0]   = 1'b0;
    REQ_VALID[0] = 1'b1;
    wait_valid(ok);
    n_checks++; if (!ok || sb.size() == 0) $display("FAIL bp_result: got no result exp result");
    else begin
      n_pass++;
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
        if (k > 0) @(negedge CLK);
        n_checks++;
        if (RES_VALID !== 1'b1 || RES_S !== e.s || RES_ID !== e.id || REQ_READY !== '0)
          $display("FAIL bp_hold%0d: got v%b s%h id%0d rdy%b exp v1 s%h id%0d rdy0",
                   k, RES_VALID, RES_S, RES_ID, REQ_READY, e.s, e.id);
        else n_pass++;
      end
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++; if (RES_VALID !== 1'b0 || REQ_READY !== 4'b0001)
        $display("FAIL bp_release: got v%b rdy%b exp v0 rdy0001", RES_VALID, REQ_READY); else n_pass++;
      @(posedge CLK); #1;
      REQ_VALID[0] = 1'b0;
      wait_valid(ok);
      n_checks++; if (!ok || sb.size() == 0) $display("FAIL bp_next: got no result exp result");
      else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++; if (RES_ID !== 2'd0 || RES_S !== e.s) $display("FAIL bp_next_val: got id%0d s%h exp id0 s%h", RES_ID, RES_S, e.s); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midop();
    bit   ok;
    exp_t e;
    RES_READY = 1'b1;
    issue(2, 32'h0000_0100, 32'h0000_0001, 1'b0, ok);
    n_checks++; if (!ok || BUSY !== 1'b1) $display("FAIL mid_exec: got grant %b busy %b exp 1/1", ok, BUSY); else n_pass++;
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if (RES_VALID !== 1'b0 || BUSY !== 1'b0) $display("FAIL mid_rst_now: got v%b busy%b exp 0/0", RES_VALID, BUSY); else n_pass++;
    sb.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    REQ_A[1*NBIT +: NBIT] = 32'h0000_0040;
    REQ_B[1*NBIT +: NBIT] = 32'h0000_0002;
    REQ_SUB[1] = 1'b1;
    REQ_A[3*NBIT +: NBIT] = 32'h0000_0300;
    REQ_B[3*NBIT +: NBIT] = 32'h0000_0003;
    REQ_SUB[3] = 1'b0;
    REQ_VALID  = 4'b1010;
    @(negedge CLK);
    n_checks++; if (REQ_READY !== 4'b0010) $display("FAIL mid_first_grant: got %b exp 0010", REQ_READY); else n_pass++;
    @(posedge CLK); #1;
    REQ_VALID = '0;
    wait_valid(ok);
    n_checks++; if (!ok || sb.size() == 0) $display("FAIL mid_result: got no result exp result");
    else begin
      n_pass++;
      e = sb.pop_front();
      n_checks++; if (RES_ID !== 2'd1 || RES_S !== e.s || RES_CO !== e.co)
        $display("FAIL mid_result_val: got id%0d s%h co%b exp id1 s%h co%b", RES_ID, RES_S, RES_CO, e.s, e.co); else n_pass++;
      n_checks++; if (sb.size() != 0) $display("FAIL mid_stale: got %0d queued exp 0", sb.size()); else n_pass++;
    end
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_SUB   = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    RES_READY = 1'b0;
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
